// File: rtl/om_fill_ctrl.sv
// Output-map fill controller: writes one frame of DEPTH elements, then holds full until the reader releases it.
// Write latency 1 cycle; no backpressure to the datapath, so data arriving while full is dropped and flagged.
module om_fill_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 784
) (
    input  logic                  OM_FILL_CTRL_Clk,
    input  logic                  OM_FILL_CTRL_Reset_InLow,
    input  logic                  OM_FILL_CTRL_Start,
    input  logic                  OM_FILL_CTRL_Data_Valid,
    input  logic [DATA_WIDTH-1:0] OM_FILL_CTRL_Data_In,
    input  logic                  OM_FILL_CTRL_Clr_In,
    input  logic                  OM_FILL_CTRL_Release,
    output logic                  OM_FILL_CTRL_Mem_We,
    output logic [ADDR_WIDTH-1:0] OM_FILL_CTRL_Mem_Addr,
    output logic [DATA_WIDTH-1:0] OM_FILL_CTRL_Mem_Data,
    output logic                  OM_FILL_CTRL_Flag_Om_Full,
    output logic                  OM_FILL_CTRL_Busy,
    output logic                  OM_FILL_CTRL_Overrun
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        FILL         = 2'd1,
        FULL         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_cnt;

    always_ff @(posedge OM_FILL_CTRL_Clk or negedge OM_FILL_CTRL_Reset_InLow) begin
        if (!OM_FILL_CTRL_Reset_InLow) begin
            state                     <= IDLE;
            wr_cnt                    <= '0;
            OM_FILL_CTRL_Mem_We       <= 1'b0;
            OM_FILL_CTRL_Mem_Addr     <= '0;
            OM_FILL_CTRL_Mem_Data     <= '0;
            OM_FILL_CTRL_Flag_Om_Full <= 1'b0;
            OM_FILL_CTRL_Busy         <= 1'b0;
            OM_FILL_CTRL_Overrun      <= 1'b0;
        end else begin
            OM_FILL_CTRL_Mem_We <= 1'b0;
            case (state)
                IDLE: begin
                    if (OM_FILL_CTRL_Start) begin
                        state                <= FILL;
                        wr_cnt               <= '0;
                        OM_FILL_CTRL_Busy    <= 1'b1;
                        OM_FILL_CTRL_Overrun <= 1'b0;
                    end
                end
                FILL: begin
                    if (OM_FILL_CTRL_Data_Valid) begin
                        OM_FILL_CTRL_Mem_We   <= 1'b1;
                        OM_FILL_CTRL_Mem_Addr <= wr_cnt;
                        OM_FILL_CTRL_Mem_Data <= OM_FILL_CTRL_Data_In;
                        // Counter parks on the last address so it never wraps into the next frame.
                        if (wr_cnt == LAST_ADDR) begin
                            state                     <= FULL;
                            OM_FILL_CTRL_Flag_Om_Full <= 1'b1;
                            OM_FILL_CTRL_Busy         <= 1'b0;
                        end else begin
                            wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                FULL: begin
                    if (OM_FILL_CTRL_Data_Valid) begin
                        OM_FILL_CTRL_Overrun <= 1'b1;
                    end
                    if (OM_FILL_CTRL_Release) begin
                        if (OM_FILL_CTRL_Clr_In) begin
                            state <= RELEASE_WAIT;
                        end else begin
                            state                     <= IDLE;
                            OM_FILL_CTRL_Flag_Om_Full <= 1'b0;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (OM_FILL_CTRL_Data_Valid) begin
                        OM_FILL_CTRL_Overrun <= 1'b1;
                    end
                    // Release already seen; only waiting for the clear generator to acknowledge.
                    if (!OM_FILL_CTRL_Clr_In) begin
                        state                     <= IDLE;
                        OM_FILL_CTRL_Flag_Om_Full <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_om_fill_ctrl.sv
// Bench for om_fill_ctrl with DEPTH=4: frame-level model compared every cycle plus literal expectations.
module tb_om_fill_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          dv    = 1'b0;
    logic [DW-1:0] din   = '0;
    logic          clr   = 1'b0;
    logic          rel   = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          flag_full;
    logic          busy;
    logic          overrun;

    om_fill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .OM_FILL_CTRL_Clk          (clk),
        .OM_FILL_CTRL_Reset_InLow  (rst_n),
        .OM_FILL_CTRL_Start        (start),
        .OM_FILL_CTRL_Data_Valid   (dv),
        .OM_FILL_CTRL_Data_In      (din),
        .OM_FILL_CTRL_Clr_In       (clr),
        .OM_FILL_CTRL_Release      (rel),
        .OM_FILL_CTRL_Mem_We       (mem_we),
        .OM_FILL_CTRL_Mem_Addr     (mem_addr),
        .OM_FILL_CTRL_Mem_Data     (mem_data),
        .OM_FILL_CTRL_Flag_Om_Full (flag_full),
        .OM_FILL_CTRL_Busy         (busy),
        .OM_FILL_CTRL_Overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame model: a frame is either being collected, complete (possibly with release pending), or absent.
    bit            m_collecting = 0;
    bit            m_complete   = 0;
    bit            m_rel_pend   = 0;
    bit            m_ovr        = 0;
    int            m_count      = 0;
    bit            e_we         = 0;
    logic [AW-1:0] e_addr       = '0;
    logic [DW-1:0] e_data       = '0;
    bit            cmp_en       = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_collecting = 0; m_complete = 0; m_rel_pend = 0; m_ovr = 0;
            m_count = 0; e_we = 0;
        end else begin
            e_we = 0;
            if (m_collecting) begin
                if (dv) begin
                    e_we    = 1;
                    e_addr  = AW'(m_count);
                    e_data  = din;
                    m_count = m_count + 1;
                    if (m_count == DEPTH) begin
                        m_collecting = 0;
                        m_complete   = 1;
                    end
                end
            end else if (m_complete) begin
                if (dv) m_ovr = 1;
                if (m_rel_pend || rel) begin
                    if (!clr) begin
                        m_complete = 0;
                        m_rel_pend = 0;
                    end else begin
                        m_rel_pend = 1;
                    end
                end
            end else if (start) begin
                m_collecting = 1;
                m_count      = 0;
                m_ovr        = 0;
            end
        end
    end

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];

    always @(posedge clk) begin
        #1;
        if (mem_we === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end
        if (cmp_en && rst_n) begin
            chk("cyc_we", mem_we, e_we);
            if (e_we) begin
                chk("cyc_addr", mem_addr, e_addr);
                chk("cyc_data", mem_data, e_data);
            end
            chk("cyc_full", flag_full, m_complete);
            chk("cyc_busy", busy, m_collecting);
            chk("cyc_ovr", overrun, m_ovr);
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic chk_log(input string name, input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({name, "_addr"}, (idx < log_addr.size()) ? 32'(log_addr[idx]) : 32'hFFFF_FFFF, 32'(a));
        chk({name, "_data"}, (idx < log_data.size()) ? 32'(log_data[idx]) : 32'hFFFF_FFFF, 32'(d));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_we"},   mem_we,    0);
        chk({name, "_addr"}, mem_addr,  0);
        chk({name, "_data"}, mem_data,  0);
        chk({name, "_full"}, flag_full, 0);
        chk({name, "_busy"}, busy,      0);
        chk({name, "_ovr"},  overrun,   0);
    endtask

    logic [DW-1:0] gap_dat[6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    bit            gap_vld[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n  = 1'b1;
        cmp_en = 1;
        @(negedge clk);

        // Straight frame of four elements
        clear_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dv  = 1'b1;
            din = DW'(8'h11 * (i + 1));
            @(negedge clk);
        end
        dv = 1'b0;
        chk("frame_full", flag_full, 1);
        chk("frame_busy", busy, 0);
        chk("frame_nwr", log_addr.size(), 4);
        chk_log("frame_w0", 0, 0, 8'h11);
        chk_log("frame_w3", 3, 3, 8'h44);

        // Data while full is dropped and flagged
        dv  = 1'b1;
        din = 8'h55;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        chk("ovr_set", overrun, 1);
        chk("ovr_nwr", log_addr.size(), 4);

        // Release while clear generator still busy
        clr = 1'b1;
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("pend_full", flag_full, 1);
            @(negedge clk);
        end
        clr = 1'b0;
        @(negedge clk);
        chk("rel_full", flag_full, 0);
        chk("rel_busy", busy, 0);
        chk("ovr_sticky", overrun, 1);

        // Release in idle has no effect
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        @(negedge clk);
        chk("idle_rel_full", flag_full, 0);
        chk("idle_rel_busy", busy, 0);

        // Gapped stream with a stray start in the middle
        clear_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("gap_ovr_clr", overrun, 0);
        for (int i = 0; i < 6; i++) begin
            dv    = gap_vld[i];
            din   = gap_dat[i];
            start = (i == 1);
            @(negedge clk);
        end
        dv    = 1'b0;
        start = 1'b0;
        chk("gap_nwr", log_addr.size(), 4);
        chk_log("gap_w0", 0, 0, 8'hA1);
        chk_log("gap_w1", 1, 1, 8'hA3);
        chk_log("gap_w2", 2, 2, 8'hA4);
        chk_log("gap_w3", 3, 3, 8'hA6);
        chk("gap_full", flag_full, 1);

        // Start coincident with release: back to idle, start not taken
        start = 1'b1;
        rel   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rel   = 1'b0;
        dv    = 1'b1;
        din   = 8'h77;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        chk("coinc_busy", busy, 0);
        chk("coinc_full", flag_full, 0);
        chk("coinc_nwr", log_addr.size(), 4);

        // Reset mid-frame
        clear_log();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dv    = 1'b1;
        din   = 8'h21;
        @(negedge clk);
        din = 8'h22;
        @(negedge clk);
        din = 8'h23;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        dv    = 1'b0;
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dv    = 1'b1;
        din   = 8'h31;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        chk("rst_nwr", log_addr.size(), 3);
        chk_log("rst_w1", 1, 1, 8'h22);
        chk_log("rst_restart", 2, 0, 8'h31);
        chk("rst_busy", busy, 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/om_fill_ctrl.md
OM_FILL_CTRL -- requirements
Module: OM_FILL_CTRL

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one output-map element.
REQ-002 Parameter ADDR_WIDTH, default 10: output-memory address width.
REQ-003 Parameter DEPTH, default 784: elements per output-map frame; 2 <= DEPTH <= 2^ADDR_WIDTH.
REQ-004 OM_FILL_CTRL_Clk  in  1  single clock; all state updates on rising edge.
REQ-005 OM_FILL_CTRL_Reset_InLow  in  1  asynchronous, active-low reset.
REQ-006 OM_FILL_CTRL_Start  in  1  one-cycle pulse: begin filling a new frame.
REQ-007 OM_FILL_CTRL_Data_Valid  in  1  OM_FILL_CTRL_Data_In carries a result this cycle.
REQ-008 OM_FILL_CTRL_Data_In  in  DATA_WIDTH  result element from the datapath.
REQ-009 OM_FILL_CTRL_Clr_In  in  1  set-enable clear from the clear generator; low = full condition acknowledged.
REQ-010 OM_FILL_CTRL_Release  in  1  one-cycle pulse from the output-memory reader: frame consumed.
REQ-011 OM_FILL_CTRL_Mem_We  out  1  output-memory write enable.
REQ-012 OM_FILL_CTRL_Mem_Addr  out  ADDR_WIDTH  output-memory write address.
REQ-013 OM_FILL_CTRL_Mem_Data  out  DATA_WIDTH  output-memory write data.
REQ-014 OM_FILL_CTRL_Flag_Om_Full  out  1  frame complete, memory full.
REQ-015 OM_FILL_CTRL_Busy  out  1  high while in FILL.
REQ-016 OM_FILL_CTRL_Overrun  out  1  sticky error: data arrived while memory full.

Function
REQ-017 FSM states SHALL be IDLE, FILL, FULL, RELEASE_WAIT; all outputs registered.
REQ-018 IDLE: Start=1 -> FILL, write counter cleared to 0; Data_Valid and Release ignored.
REQ-019 FILL: each cycle with Data_Valid=1 SHALL produce, on the next rising edge, Mem_We=1, Mem_Addr=counter, Mem_Data=Data_In, then counter+1 (latency 1 cycle).
REQ-020 FILL: Mem_We SHALL be 0 in any cycle following Data_Valid=0; Start in FILL is ignored.
REQ-021 Accepting the element at counter=DEPTH-1 SHALL move to FULL and raise Flag_Om_Full on the same edge as that final Mem_We; counter never exceeds DEPTH-1 (no wrap).
REQ-022 FULL: Flag_Om_Full held 1, Mem_We 0; Data_Valid=1 SHALL set Overrun=1 and the data is discarded.
REQ-023 FULL: Release=1 with Clr_In=0 -> IDLE, Flag_Om_Full cleared on that edge.
REQ-024 FULL: Release=1 with Clr_In=1 -> RELEASE_WAIT (release pending, flag stays 1).
REQ-025 RELEASE_WAIT: first cycle with Clr_In=0 -> IDLE, flag cleared; Data_Valid here also sets Overrun.
REQ-026 Release outside FULL/RELEASE_WAIT SHALL be ignored.
REQ-027 Start coincident with Release in FULL SHALL be ignored (IDLE entered, new Start required).
REQ-028 Overrun SHALL clear only on reset or on Start accepted in IDLE.
REQ-029 Busy=1 exactly when state is FILL.

Reset
REQ-030 Reset_InLow=0 SHALL immediately (asynchronously) force IDLE, counter=0, Mem_We=0, Mem_Addr=0, Mem_Data=0, Flag_Om_Full=0, Busy=0, Overrun=0.
REQ-031 Reset mid-FILL SHALL abandon the frame; no further writes until a new Start after reset release.
REQ-032 Reset release is synchronous to the next rising edge; first Start is accepted on the first edge after deassertion.

Verification
REQ-033 DEPTH=4: Start, 4 consecutive Data_Valid with 0x11..0x44 -> writes addr 0..3 data 0x11..0x44, Flag_Om_Full=1 with final write, Busy=0.
REQ-034 Gapped stream: Data_Valid pattern 1,0,1,1,0,1 -> exactly 4 writes, addresses contiguous 0..3, no Mem_We on gap cycles.
REQ-035 Full then Data_Valid=1 with 0x55 -> no Mem_We, Overrun=1, persists until next Start.
REQ-036 Full, Clr_In=1, Release pulse -> flag stays 1; Clr_In drops 3 cycles later -> flag 0 next edge, state IDLE.
REQ-037 Reset asserted after 2 of 4 writes -> all outputs 0 immediately; new Start restarts at addr 0.
REQ-038 Start in FILL and Release in IDLE -> no effect on counter, flag, or state.
